// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam int unsigned PS2_DATA_BITS = 8;
  localparam logic PS2_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ps2_filter.sv
// Synchroniser plus debounce for the PS/2 clock pin; emits the filtered level and a
// one-cycle strobe on each filtered falling edge.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   filt_q;
  logic                   fall_q;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  // The level only flips after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= PS2_IDLE_LEVEL;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (sync_s == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_q <= sync_s;
        cnt_q  <= '0;
        fall_q <= filt_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = filt_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames, checks framing and odd
// parity, and strobes each good scan-code byte.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT     = 100_000
) (
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [PS2_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     rx_err,
  output logic                     busy
);

  localparam int unsigned BW = $clog2(PS2_DATA_BITS);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic                     filt_clk;
  logic                     fall;
  logic                     sample;
  logic [SYNC_STAGES-1:0]   data_sync_q;
  logic                     data_s;
  ps2_state_e               state_q;
  logic [BW-1:0]            bit_cnt_q;
  logic [PS2_DATA_BITS-1:0] shreg_q;
  logic                     parity_q;
  logic [TW-1:0]            tcnt_q;

  ps2_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_clk_filter (
    .clk  (clk_100MHz),
    .reset(reset),
    .pin  (ps2_clk),
    .level(filt_clk),
    .fall (fall)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      data_sync_q <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
    end else begin
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign sample = fall & ~filt_clk;
  assign busy   = (state_q != StIdle);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      tcnt_q    <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (state_q == StIdle || sample) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      // A stalled frame is dropped; rx_data keeps the last good byte.
      if (state_q != StIdle && !sample && tcnt_q == TW'(TIMEOUT - 1)) begin
        rx_err  <= 1'b1;
        state_q <= StIdle;
        tcnt_q  <= '0;
      end else if (sample) begin
        unique case (state_q)
          StIdle: begin
            if (data_s != PS2_IDLE_LEVEL) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shreg_q   <= {data_s, shreg_q[PS2_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            parity_q <= data_s;
            state_q  <= StStop;
          end
          StStop: begin
            if (data_s == PS2_IDLE_LEVEL && (^{shreg_q, parity_q})) begin
              rx_data  <= shreg_q;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Randomised and directed bench for ps2_rx with a queue-based scoreboard.
module tb_ps2_rx;

  localparam int HALF      = 50;
  localparam int TIMEOUT_T = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_good = 8'h00;

  always #5 clk = ~clk;

  ps2_rx #(
    .SYNC_STAGES(2),
    .FILT_LEN   (8),
    .TIMEOUT    (TIMEOUT_T)
  ) dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Reference: a frame is good iff stop is 1 and data plus parity has an odd count of ones.
  function automatic void push_frame(input logic [7:0] data, input bit par, input bit stop);
    ev_t ev;
    ev.err  = !(stop && ((($countones(data) + int'(par)) % 2) == 1));
    ev.data = data;
    exp_q.push_back(ev);
  endfunction

  always @(negedge clk) begin
    if (!reset && (rx_valid || rx_err)) begin
      check("valid_err_exclusive", 32'(rx_valid & rx_err), 0);
      check("busy_at_pulse", 32'(busy), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, rx_valid, rx_err}, 0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("pulse_is_err", 32'(rx_err), 32'(mon_ev.err));
        if (!mon_ev.err) last_good = mon_ev.data;
        check("rx_data", 32'(rx_data), 32'(last_good));
      end
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        repeat (10) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 13) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit par, input bit stop,
                            input int glitch_bit);
    push_frame(data, par, stop);
    send_bits({stop, par, data, 1'b0}, 11, glitch_bit);
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit         p;
    bit         s;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_rx_err", 32'(rx_err), 0);
    check("reset_busy", 32'(busy), 0);

    send_frame(8'h1C, 1'b0, 1'b1, -1);
    drain("good", 1000);
    @(negedge clk);
    check("good_busy_after", 32'(busy), 0);
    check("good_rx_data_held", 32'(rx_data), 32'h1C);

    send_frame(8'hF0, 1'b1, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    drain("b2b", 1000);

    send_frame(8'h1C, 1'b1, 1'b1, -1);
    send_frame(8'h23, 1'b0, 1'b0, -1);
    drain("bad", 1000);
    @(negedge clk);
    check("bad_rx_data_kept", 32'(rx_data), 32'h1C);

    // Start plus four data bits, then the line stalls high.
    exp_q.push_back('{err: 1'b1, data: 8'h00});
    send_bits({3'b111, 8'h23, 1'b0}, 5, -1);
    repeat (TIMEOUT_T - 200) @(posedge clk);
    @(negedge clk);
    check("timeout_not_early", exp_q.size(), 1);
    check("timeout_busy_before", 32'(busy), 1);
    drain("timeout", 1000);
    @(negedge clk);
    check("timeout_busy_after", 32'(busy), 0);
    check("timeout_rx_data_kept", 32'(rx_data), 32'h1C);
    send_frame(8'h23, 1'b0, 1'b1, -1);
    drain("after_timeout", 1000);

    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_idle_busy", 32'(busy), 0);
    send_frame(8'h1C, 1'b0, 1'b1, 4);
    drain("glitch_frame", 1000);

    send_bits({3'b111, 8'h5A, 1'b0}, 6, -1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    last_good = 8'h00;
    repeat (200) @(negedge clk);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_rx_data", 32'(rx_data), 0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    drain("after_reset", 1000);

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      p = ~(^d);
      if ($urandom_range(0, 4) == 0) p = ~p;
      s = ($urandom_range(0, 9) != 0);
      send_frame(d, p, s, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1);
    end
    drain("random", 1000);
    @(negedge clk);
    check("final_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
